// File: rtl/regfile_multiport.sv
// Multi-port register file: NUM_READ registered reads, two writes, clear sequencer.
// Optional macro REGFILE_BYPASS_EN selects write-first forwarding on read/write collisions.
module regfile_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clearReq,
    output logic                         ready,
    input  logic [NUM_READ-1:0]          readEn,
    input  logic [NUM_READ*ADDR_W-1:0]   readAddr,
    output logic [NUM_READ*DATA_W-1:0]   readData,
    input  logic                         writeEnA,
    input  logic [ADDR_W-1:0]            writeAddrA,
    input  logic [DATA_W-1:0]            writeDataA,
    input  logic                         writeEnB,
    input  logic [ADDR_W-1:0]            writeAddrB,
    input  logic [DATA_W-1:0]            writeDataB
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_addr [NUM_READ];
    logic [DATA_W-1:0] rd_val [NUM_READ];
    logic              wr_a;
    logic              wr_b;

    // Effective write strobes: only in READY, and never into a hard-wired zero entry
    always_comb begin
        wr_a = writeEnA && (state == ST_READY)
            && !((ZERO_REG != 0) && (writeAddrA == '0));
        wr_b = writeEnB && (state == ST_READY)
            && !((ZERO_REG != 0) && (writeAddrB == '0));
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_CLEAR;
        else       state <= state_nxt;
    end

    // Next state: leave CLEAR after the last entry, enter it on clearReq
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_CLEAR: if (clr_ptr == {ADDR_W{1'b1}}) state_nxt = ST_READY;
            ST_READY: if (clearReq) state_nxt = ST_CLEAR;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    // Outputs of the sequencer
    always_comb begin
        ready = (state == ST_READY);
    end

    // Clear pointer walks every entry while clearing, parked at 0 otherwise
    always_ff @(posedge clk) begin
        if (reset)                  clr_ptr <= '0;
        else if (state == ST_CLEAR) clr_ptr <= clr_ptr + 1'b1;
        else                        clr_ptr <= '0;
    end

    // Storage: clear one entry per cycle, else A then B so B wins on a tie
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem[clr_ptr] <= '0;
            end else begin
                if (wr_a) mem[writeAddrA] <= writeDataA;
                if (wr_b) mem[writeAddrB] <= writeDataB;
            end
        end
    end

    // Per-port read value, with optional same-cycle write forwarding
    always_comb begin
        for (int p = 0; p < NUM_READ; p++) begin
            rd_addr[p] = readAddr[p*ADDR_W +: ADDR_W];
            rd_val[p]  = mem[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            if (wr_a && (writeAddrA == rd_addr[p])) rd_val[p] = writeDataA;
            if (wr_b && (writeAddrB == rd_addr[p])) rd_val[p] = writeDataB;
`endif
            if ((ZERO_REG != 0) && (rd_addr[p] == '0)) rd_val[p] = '0;
        end
    end

    // Registered read ports: zero while clearing, hold when not enabled
    always_ff @(posedge clk) begin
        if (reset) begin
            readData <= '0;
        end else begin
            for (int p = 0; p < NUM_READ; p++) begin
                if (state == ST_CLEAR)
                    readData[p*DATA_W +: DATA_W] <= '0;
                else if (readEn[p])
                    readData[p*DATA_W +: DATA_W] <= rd_val[p];
            end
        end
    end

endmodule
